// File: rtl/steer_quad_sched.sv
// steer_quad_sched: turns two players' digital left/right steering levels into
// quadrature phase pairs. One shared rate divider produces scheduler ticks,
// and the ticks are handed out round-robin to the two players. Each player
// runs a small IDLE/SLOW/FAST acceleration machine: SLOW steps on every
// other service tick and FAST steps on every service tick.
module steer_quad_sched #(
    parameter int CLKDIV      = 22500,  // clocks per scheduler tick, 2..65535
    parameter int ACCEL_STEPS = 8       // SLOW steps before FAST, 1..255
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       enable,
    input  logic       right0,
    input  logic       left0,
    input  logic       right1,
    input  logic       left1,
    output logic [1:0] steer0,
    output logic [1:0] steer1,
    output logic       tick
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SLOW,
        ST_FAST
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_RIGHT,
        DIR_LEFT
    } dir_t;

    localparam logic [15:0] DIV_LAST  = 16'(CLKDIV - 1);
    localparam logic [7:0]  ACCEL_LIM = 8'(ACCEL_STEPS);

    // One quadrature step. Right runs 00->01->11->10->00; left runs the
    // same cycle backwards. Exactly one bit changes per step.
    function automatic logic [1:0] quad_step(input logic [1:0] cur, input logic go_left);
        logic [1:0] nxt;
        if (!go_left) begin
            case (cur)
                2'b00:   nxt = 2'b01;
                2'b01:   nxt = 2'b11;
                2'b11:   nxt = 2'b10;
                default: nxt = 2'b00;
            endcase
        end else begin
            case (cur)
                2'b00:   nxt = 2'b10;
                2'b10:   nxt = 2'b11;
                2'b11:   nxt = 2'b01;
                default: nxt = 2'b00;
            endcase
        end
        return nxt;
    endfunction

    // Bit order matches the per-player slices used below: {L1, R1, L0, R0}.
    logic [3:0] raw_in;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    assign raw_in = {left1, right1, left0, right0};

    // Two-flop synchronisers for the direction levels arriving from clk_sys.
    // They run even while disabled; the player machines only sample them on a
    // tick, so a press and release inside a disabled window is never seen.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    logic [15:0] div_q;
    logic [15:0] div_d;
    logic        turn_q;
    logic        turn_d;
    logic        tick_w;

    // The tick is the terminal count of the divider, gated by enable.
    assign tick_w = enable && (div_q == DIV_LAST);
    assign tick   = tick_w;

    // Divider next-state: count while enabled, wrap on the tick, and hand the
    // turn to the other player on every tick.
    always_comb begin
        div_d  = div_q;
        turn_d = turn_q;
        if (enable) begin
            div_d = tick_w ? 16'd0 : div_q + 16'd1;
        end
        if (tick_w) begin
            turn_d = ~turn_q;
        end
    end

    // Divider and turn registers; both hold their value while disabled.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            turn_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            turn_q <= turn_d;
        end
    end

    logic [1:0] steer_all [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_player
        logic       req_r;
        logic       req_l;
        logic       service;
        dir_t       dir_in;
        state_t     state_q;
        state_t     state_d;
        dir_t       dir_q;
        dir_t       dir_d;
        logic       phase_q;
        logic       phase_d;
        logic [7:0] cnt_q;
        logic [7:0] cnt_d;
        logic [1:0] steer_q;
        logic [1:0] steer_d;

        assign req_r   = sync2_q[2*gi];
        assign req_l   = sync2_q[2*gi+1];
        assign service = tick_w && (turn_q == 1'(gi));

        // Resolve the synchronised levels: both pressed cancels to NONE.
        always_comb begin
            dir_in = DIR_NONE;
            if (req_r && !req_l) begin
                dir_in = DIR_RIGHT;
            end else if (req_l && !req_r) begin
                dir_in = DIR_LEFT;
            end
        end

        // Acceleration machine, evaluated only on this player's service tick.
        always_comb begin
            state_d = state_q;
            dir_d   = dir_q;
            phase_d = phase_q;
            cnt_d   = cnt_q;
            steer_d = steer_q;
            if (service) begin
                if (dir_in == DIR_NONE) begin
                    // Releasing from any state returns to IDLE with no step.
                    state_d = ST_IDLE;
                    dir_d   = DIR_NONE;
                    phase_d = 1'b0;
                    cnt_d   = 8'd0;
                end else if (state_q == ST_IDLE || dir_in != dir_q) begin
                    // Fresh press or reversal: step at once and restart SLOW.
                    steer_d = quad_step(steer_q, dir_in == DIR_LEFT);
                    dir_d   = dir_in;
                    phase_d = 1'b1;
                    cnt_d   = 8'd1;
                    state_d = (ACCEL_LIM == 8'd1) ? ST_FAST : ST_SLOW;
                end else if (state_q == ST_SLOW) begin
                    if (phase_q) begin
                        // Half-rate gap between SLOW steps.
                        phase_d = 1'b0;
                    end else begin
                        steer_d = quad_step(steer_q, dir_q == DIR_LEFT);
                        phase_d = 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 >= ACCEL_LIM) begin
                            state_d = ST_FAST;
                        end
                    end
                end else begin
                    // FAST, same direction: step every service tick.
                    steer_d = quad_step(steer_q, dir_q == DIR_LEFT);
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
        end

        // Player state registers; asynchronous reset clears the outputs at once.
        always_ff @(posedge CLK or posedge reset) begin
            if (reset) begin
                state_q <= ST_IDLE;
                dir_q   <= DIR_NONE;
                phase_q <= 1'b0;
                cnt_q   <= 8'd0;
                steer_q <= 2'b00;
            end else begin
                state_q <= state_d;
                dir_q   <= dir_d;
                phase_q <= phase_d;
                cnt_q   <= cnt_d;
                steer_q <= steer_d;
            end
        end

        assign steer_all[gi] = steer_q;
    end

    assign steer0 = steer_all[0];
    assign steer1 = steer_all[1];

endmodule
